// File: rtl/input_debounce_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : input_debounce_reader_if
//  Description : Core-side read bus of the switch/button input peripheral:
//                read strobe, word select, registered read data and the
//                key-event indication.
//  Revision    : 1.0  initial release
// ============================================================================
interface input_debounce_reader_if;
    logic        rd_en;
    logic [1:0]  addr;
    logic [31:0] rd_data;
    logic        key_event;

    // Core / bus side
    modport master (
        output rd_en,
        output addr,
        input  rd_data,
        input  key_event
    );

    // Peripheral side
    modport slave (
        input  rd_en,
        input  addr,
        output rd_data,
        output key_event
    );
endinterface
`default_nettype wire

// File: rtl/input_debounce_reader.sv
`default_nettype none
// ============================================================================
//  Module      : input_debounce_reader
//  Description : Memory-mapped input peripheral. Synchronizes and debounces
//                slide switches (SW) and active-low push-buttons (KEY),
//                captures button presses as sticky clear-on-read flags and
//                returns everything through one registered read port.
//  Revision    : 1.0  initial release
// ============================================================================
module input_debounce_reader #(
    parameter int SW_WIDTH        = 10,
    parameter int KEY_WIDTH       = 4,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [SW_WIDTH-1:0]  SW,
    input  logic [KEY_WIDTH-1:0] KEY,
    input_debounce_reader_if.slave bus
);

    // All inputs are handled as one vector: switches low, keys high.
    localparam int                   c_N        = SW_WIDTH + KEY_WIDTH;
    localparam int                   c_CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W-1:0]   c_CNT_MAX  = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    // Switches idle at 0, buttons idle at 1 (released, active-low pins).
    localparam logic [c_N-1:0]       c_IDLE_VAL = {{KEY_WIDTH{1'b1}}, {SW_WIDTH{1'b0}}};
    localparam logic [1:0]           c_ADDR_SW    = 2'd0;
    localparam logic [1:0]           c_ADDR_KEY   = 2'd1;
    localparam logic [1:0]           c_ADDR_FLAGS = 2'd2;

    logic [c_N-1:0]       r_meta;
    logic [c_N-1:0]       r_sync;
    logic [c_N-1:0]       w_stable;
    logic [c_N-1:0]       w_accept;
    logic [SW_WIDTH-1:0]  w_sw_stable;
    logic [KEY_WIDTH-1:0] w_key_stable;
    logic [KEY_WIDTH-1:0] w_key_fall;
    logic [KEY_WIDTH-1:0] r_flag;
    logic                 w_rd_clr;
    logic [31:0]          w_rd_word;
    logic [31:0]          r_rd_data;

    // Two-flop synchronizer for every raw pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= c_IDLE_VAL;
            r_sync <= c_IDLE_VAL;
        end else begin
            r_meta <= {KEY, SW};
            r_sync <= r_meta;
        end
    end

    // Per-bit debouncer: a change is accepted only after the synchronized
    // value has differed from the stable value for DEBOUNCE_CYCLES edges.
    for (genvar gi = 0; gi < c_N; gi++) begin : g_debounce
        logic [c_CNT_W-1:0] r_cnt;
        logic               r_stable;

        assign w_accept[gi] = (r_sync[gi] != r_stable) && (r_cnt == c_CNT_MAX);
        assign w_stable[gi] = r_stable;

        // Count while the input disagrees; any agreement restarts the count.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt    <= '0;
                r_stable <= c_IDLE_VAL[gi];
            end else if (r_sync[gi] == r_stable) begin
                r_cnt    <= '0;
            end else if (r_cnt == c_CNT_MAX) begin
                r_stable <= r_sync[gi];
                r_cnt    <= '0;
            end else begin
                r_cnt    <= r_cnt + c_CNT_W'(1);
            end
        end
    end

    assign w_sw_stable  = w_stable[SW_WIDTH-1:0];
    assign w_key_stable = w_stable[c_N-1:SW_WIDTH];
    // A key being accepted while its stable level is 1 is a 1->0 press edge,
    // so the flag sets on the same edge as the stable transition.
    assign w_key_fall   = w_accept[c_N-1:SW_WIDTH] & w_key_stable;
    assign w_rd_clr     = bus.rd_en && (bus.addr == c_ADDR_FLAGS);

    // Sticky press flags: a read clears them, but a press landing on the
    // same edge wins so no event is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flag <= '0;
        end else begin
            r_flag <= (w_rd_clr ? '0 : r_flag) | w_key_fall;
        end
    end

    // Register-map select, using pre-edge state.
    always_comb begin
        w_rd_word = '0;
        case (bus.addr)
            c_ADDR_SW:    w_rd_word[SW_WIDTH-1:0]  = w_sw_stable;
            c_ADDR_KEY:   w_rd_word[KEY_WIDTH-1:0] = ~w_key_stable;
            c_ADDR_FLAGS: w_rd_word[KEY_WIDTH-1:0] = r_flag;
            default:      w_rd_word = '0;
        endcase
    end

    // Registered read port; holds its value between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else if (bus.rd_en) begin
            r_rd_data <= w_rd_word;
        end
    end

    assign bus.rd_data   = r_rd_data;
    assign bus.key_event = |r_flag;

endmodule
`default_nettype wire

// File: tb/tb_input_debounce_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_input_debounce_reader
//  Description : Self-checking bench for input_debounce_reader. Expected read
//                words are queued when a read is issued and compared when the
//                registered read data appears.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_input_debounce_reader;

    localparam int SW_W = 10;
    localparam int KEY_W = 4;
    localparam int DB = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [SW_W-1:0]  sw;
    logic [KEY_W-1:0] key;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    input_debounce_reader_if bus();

    input_debounce_reader #(
        .SW_WIDTH        (SW_W),
        .KEY_WIDTH       (KEY_W),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .SW    (sw),
        .KEY   (key),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Compare the registered read data one step after each read edge.
    always @(posedge clk) begin
        if (rst_n && bus.rd_en) begin
            logic [31:0] e;
            string       t;
            if (exp_q.size() == 0) begin
                #1 check_val("sb_underflow", 32'd0, 32'd1);
            end else begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                #1 check_val(t, bus.rd_data, e);
            end
        end
    end

    task automatic idle(input int n);
        bus.rd_en = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] e, input string t);
        bus.rd_en = 1'b1;
        bus.addr  = a;
        exp_q.push_back(e);
        tag_q.push_back(t);
        @(negedge clk);
        bus.rd_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with all pins driven away from idle.
        rst_n     = 1'b0;
        sw        = 10'h3FF;
        key       = 4'h0;
        bus.rd_en = 1'b0;
        bus.addr  = 2'd0;
        repeat (3) @(negedge clk);
        check_val("rst_rd_data", bus.rd_data, 32'h0);
        check_val("rst_key_event", 32'(bus.key_event), 32'h0);
        rst_n = 1'b1;
        sw    = '0;
        key   = 4'hF;
        rd(2'd1, 32'h0, "rst_addr1");
        idle(3);

        // Switch debounce: accepted on edge 6, visible from the read at edge 7.
        sw = 10'h2A5;
        for (int k = 1; k <= 9; k++)
            rd(2'd0, (k <= 6) ? 32'h0 : 32'h2A5, "sw_debounce");

        // Three-cycle glitch on KEY[2] must never be accepted.
        key = 4'b1011;
        for (int k = 1; k <= 10; k++) begin
            if (k == 4) key = 4'hF;
            rd(2'd1, 32'h0, "glitch_level");
            check_val("glitch_event", 32'(bus.key_event), 32'h0);
        end
        rd(2'd2, 32'h0, "glitch_flags");

        // Press KEY[1] for 10 cycles, then release.
        key = 4'b1101;
        for (int k = 1; k <= 10; k++)
            rd(2'd1, (k >= 7) ? 32'h2 : 32'h0, "press_level");
        check_val("press_event", 32'(bus.key_event), 32'h1);
        key = 4'hF;
        idle(8);
        check_val("release_keeps_flag", 32'(bus.key_event), 32'h1);
        rd(2'd2, 32'h2, "press_flags");
        check_val("clr_event", 32'(bus.key_event), 32'h0);
        rd(2'd2, 32'h0, "flags_after_clr");

        // Collision: KEY[3] accepted on the same edge as an addr-2 read,
        // with flag 0 already set.
        key = 4'b1110;
        idle(8);
        key = 4'hF;
        idle(8);
        check_val("flag0_event", 32'(bus.key_event), 32'h1);
        key = 4'b0111;
        idle(5);
        rd(2'd2, 32'h1, "collision_word");
        check_val("collision_event", 32'(bus.key_event), 32'h1);
        key = 4'hF;
        idle(8);
        rd(2'd2, 32'h8, "collision_flags");
        check_val("collision_cleared", 32'(bus.key_event), 32'h0);

        // Set a flag again so the async reset has something to clear.
        key = 4'b1011;
        idle(8);
        key = 4'hF;
        idle(8);
        check_val("pre_rst_event", 32'(bus.key_event), 32'h1);

        // Async reset two cycles into a switch debounce count.
        sw = 10'h155;
        rd(2'd0, 32'h2A5, "pre_rst_sw");
        idle(3);
        #2 rst_n = 1'b0;
        #1;
        check_val("async_rst_data", bus.rd_data, 32'h0);
        check_val("async_rst_event", 32'(bus.key_event), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 9; k++)
            rd(2'd0, (k <= 6) ? 32'h0 : 32'h155, "post_rst_sw");

        idle(2);
        check_val("sb_drain", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
